ddr4_iod_dly_ctrl: RTL and testbench

//   Upstream driver of the DELAY_LINE_* port group on one DDR4 PHY IOD lane (e.g. CS0_N).

---
 rtl/ddr_phy_dly_pkg.sv | 8 +
 rtl/ddr4_iod_dly_ctrl_if.sv | 11 +
 rtl/ddr4_iod_dly_ctrl.sv | 137 +++++++++++++
 tb/tb_ddr4_iod_dly_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_phy_dly_pkg.sv
// ddr_phy_dly_pkg: op codes and FSM states shared by the delay-line controller and training sequencer
package ddr_phy_dly_pkg;
  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_SET  = 2'b11;
  typedef enum logic [2:0] {INIT_LOAD, IDLE, SETUP, MOVE, SETTLE, LOAD_P, DONE_S} dly_state_e;
endpackage

// File: rtl/ddr4_iod_dly_ctrl_if.sv
// ddr4_iod_dly_ctrl_if: tap request/completion handshake between sequencer and delay controller
interface ddr4_iod_dly_ctrl_if #(parameter int TAP_W = 8) ();
  logic             REQ_VALID;
  logic             REQ_READY;
  logic [1:0]       REQ_OP;
  logic [TAP_W-1:0] REQ_ARG;
  logic             DONE;
  logic             DONE_ERR;
  modport master (output REQ_VALID, REQ_OP, REQ_ARG, input REQ_READY, DONE, DONE_ERR);
  modport slave (input REQ_VALID, REQ_OP, REQ_ARG, output REQ_READY, DONE, DONE_ERR);
endinterface

// File: rtl/ddr4_iod_dly_ctrl.sv
// ddr4_iod_dly_ctrl: turns tap requests into spaced MOVE/LOAD strobes for one IOD delay line and tracks its tap
module ddr4_iod_dly_ctrl
  import ddr_phy_dly_pkg::*;
#(
  parameter int TAP_W         = 8,
  parameter int TAP_MAX       = 127,
  parameter int RESET_TAP     = 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int DIR_INC       = 1
) (
  input  logic               FAB_CLK,
  input  logic               SYNC_RST,
  ddr4_iod_dly_ctrl_if.slave req,
  input  logic               CLR_ERR,
  output logic               ERR_RANGE,
  output logic [TAP_W-1:0]   TAP_POS,
  output logic               DELAY_LINE_MOVE_0,
  output logic               DELAY_LINE_DIRECTION_0,
  output logic               DELAY_LINE_LOAD_0,
  input  logic               DELAY_LINE_OUT_OF_RANGE_0
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TAP_W-1:0] TMAX = TAP_W'(TAP_MAX);
  localparam logic [TAP_W-1:0] TRST = TAP_W'(RESET_TAP);
  localparam logic [CW-1:0] CLD = CW'(SETTLE_CYCLES - 1);
  localparam logic DINC = 1'(DIR_INC);
  dly_state_e state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [TAP_W-1:0] tap_q, tap_d, steps_q, steps_d, set_mag, req_mag;
  logic [CW-1:0] cnt_q, cnt_d;
  logic init_q, init_d, dir_q, dir_d, move_q, move_d, load_q, load_d;
  logic ready_q, ready_d, done_q, done_d, derr_q, derr_d, err_q, err_d;
  logic set_up, req_up, blocked;
  assign set_up  = req.REQ_ARG >= tap_q;
  assign set_mag = set_up ? req.REQ_ARG - tap_q : tap_q - req.REQ_ARG;
  assign req_mag = req.REQ_OP == OP_SET ? set_mag : req.REQ_ARG;
  assign req_up  = req.REQ_OP == OP_INC || (req.REQ_OP == OP_SET && set_up);
  assign blocked = dir_q == DINC ? tap_q == TMAX : tap_q == '0;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tap_d   = tap_q;
    steps_d = steps_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    dir_d   = dir_q;
    derr_d  = 1'b0;
    case (state_q)
      INIT_LOAD: begin
        state_d = SETTLE;
        cnt_d   = CLD;
      end
      IDLE: if (req.REQ_VALID) begin
        op_d = req.REQ_OP;
        if (req.REQ_OP == OP_LOAD) state_d = LOAD_P;
        else if (req.REQ_OP == OP_SET && req.REQ_ARG > TMAX) begin
          state_d = DONE_S;
          derr_d  = 1'b1;
        end else if (req_mag == '0) state_d = DONE_S;
        else begin
          state_d = SETUP;
          steps_d = req_mag;
          dir_d   = req_up ? DINC : ~DINC;
        end
      end
      SETUP: begin
        state_d = blocked ? DONE_S : MOVE;
        derr_d  = blocked;
      end
      MOVE: begin
        state_d = SETTLE;
        cnt_d   = CLD;
        steps_d = steps_q - TAP_W'(1);
        tap_d   = dir_q == DINC ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
      end
      LOAD_P: begin
        state_d = SETTLE;
        cnt_d   = CLD;
        tap_d   = TRST;
      end
      SETTLE: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (init_q) begin
          state_d = IDLE;
          init_d  = 1'b0;
        end else if (op_q == OP_LOAD || (!DELAY_LINE_OUT_OF_RANGE_0 && steps_q == '0)) state_d = DONE_S;
        else if (DELAY_LINE_OUT_OF_RANGE_0 || blocked) begin
          state_d = DONE_S;
          derr_d  = 1'b1;
        end else state_d = MOVE;
      default: state_d = IDLE;
    endcase
    move_d  = state_d == MOVE;
    load_d  = state_q == INIT_LOAD || state_d == LOAD_P;
    ready_d = state_d == IDLE;
    done_d  = state_d == DONE_S;
    err_d   = derr_d || (err_q && !CLR_ERR);
  end
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_q <= INIT_LOAD;
      op_q    <= OP_LOAD;
      tap_q   <= TRST;
      steps_q <= '0;
      cnt_q   <= '0;
      init_q  <= 1'b1;
      dir_q   <= DINC;
      move_q  <= 1'b0;
      load_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      derr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tap_q   <= tap_d;
      steps_q <= steps_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      dir_q   <= dir_d;
      move_q  <= move_d;
      load_q  <= load_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      derr_q  <= derr_d;
      err_q   <= err_d;
    end
  end
  assign req.REQ_READY          = ready_q;
  assign req.DONE               = done_q;
  assign req.DONE_ERR           = derr_q;
  assign ERR_RANGE              = err_q;
  assign TAP_POS                = tap_q;
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = dir_q;
  assign DELAY_LINE_LOAD_0      = load_q;
endmodule

// File: tb/tb_ddr4_iod_dly_ctrl.sv
// tb_ddr4_iod_dly_ctrl: directed and random tap requests checked against a tap-arithmetic reference model
module tb_ddr4_iod_dly_ctrl;
  import ddr_phy_dly_pkg::*;
  localparam int S = 4;
  localparam int NONE = 1000;
  logic clk = 1'b0, rst = 1'b1, clr_err = 1'b0;
  logic err_range, mv, dir, ld, oor;
  logic [7:0] tap_pos;
  int cyc = 0, n_moves = 0, n_loads = 0, n_done = 0, done_cyc = 0, load_cyc = 0, last_p = -1000, oor_lim = 0;
  logic done_err = 1'b0, oor_en = 1'b0, sticky = 1'b0;
  int mv_cyc[$];
  logic mv_dir[$];
  int n_chk = 0, n_fail = 0, mtap = 1;
  ddr4_iod_dly_ctrl_if #(.TAP_W(8)) bus ();
  assign oor = oor_en && (n_moves >= oor_lim);
  ddr4_iod_dly_ctrl #(.TAP_W(8), .TAP_MAX(127), .RESET_TAP(1), .SETTLE_CYCLES(S), .DIR_INC(1)) dut (
    .FAB_CLK(clk),
    .SYNC_RST(rst),
    .req(bus),
    .CLR_ERR(clr_err),
    .ERR_RANGE(err_range),
    .TAP_POS(tap_pos),
    .DELAY_LINE_MOVE_0(mv),
    .DELAY_LINE_DIRECTION_0(dir),
    .DELAY_LINE_LOAD_0(ld),
    .DELAY_LINE_OUT_OF_RANGE_0(oor)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) last_p = -1000;
    if (mv || ld) begin
      chk("move_load_overlap", 32'(mv && ld), 0);
      if (last_p > -1000) chk("pulse_gap_ok", 32'(cyc - last_p > S), 1);
      last_p = cyc;
    end
    if (mv) begin
      n_moves++;
      mv_cyc.push_back(cyc);
      mv_dir.push_back(dir);
    end
    if (ld) begin
      n_loads++;
      load_cyc = cyc;
    end
    if (bus.DONE) begin
      n_done++;
      done_cyc = cyc;
      done_err = bus.DONE_ERR;
    end
  end
  function automatic void model(input int tap, input logic [1:0] op, input int arg, input int oor_at,
                                output int e_tap, output int e_moves, output int e_err, output int e_lat, output int e_dir);
    int tgt, n, room;
    e_tap = tap; e_moves = 0; e_err = 0; e_lat = 1; e_dir = 0;
    if (op == OP_LOAD) begin
      e_tap = 1; e_lat = 2 + S;
      return;
    end
    if (op == OP_SET && arg > 127) begin
      e_err = 1;
      return;
    end
    tgt = op == OP_INC ? tap + arg : op == OP_DEC ? tap - arg : arg;
    n = tgt > tap ? tgt - tap : tap - tgt;
    if (n == 0) return;
    e_dir = tgt > tap;
    room = e_dir ? 127 - tap : tap;
    e_moves = n;
    if (room < e_moves) e_moves = room;
    if (oor_at < e_moves) e_moves = oor_at;
    e_err = (e_moves < n || oor_at <= e_moves) ? 1 : 0;
    e_tap = e_dir ? tap + e_moves : tap - e_moves;
    e_lat = 2 + e_moves * (1 + S);
  endfunction
  task automatic wait_ready();
    int k = 0;
    while (!bus.REQ_READY && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("ready_seen", 32'(bus.REQ_READY), 1);
  endtask
  task automatic do_reset();
    int c0, l0, k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_move", 32'(mv), 0);
    chk("rst_load", 32'(ld), 0);
    chk("rst_done", 32'(bus.DONE), 0);
    chk("rst_done_err", 32'(bus.DONE_ERR), 0);
    chk("rst_err_range", 32'(err_range), 0);
    chk("rst_ready", 32'(bus.REQ_READY), 0);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_tap", 32'(tap_pos), 1);
    l0 = n_loads;
    rst = 1'b0;
    c0 = cyc;
    k = 0;
    while (!bus.REQ_READY && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("init_ready_lat", 32'(cyc - c0), S + 1);
    chk("init_load_cnt", 32'(n_loads - l0), 1);
    chk("init_load_early", 32'(load_cyc - c0 >= 1 && load_cyc - c0 <= 2), 1);
    chk("init_tap", 32'(tap_pos), 1);
    mtap = 1;
    sticky = 1'b0;
  endtask
  task automatic run_req(input logic [1:0] op, input int arg, input int oor_at);
    int e_tap, e_moves, e_err, e_lat, e_dir, t, d0, l0, k;
    wait_ready();
    model(mtap, op, arg, oor_at, e_tap, e_moves, e_err, e_lat, e_dir);
    mv_cyc.delete();
    mv_dir.delete();
    oor_lim = n_moves + oor_at;
    oor_en = oor_at != NONE;
    d0 = n_done;
    l0 = n_loads;
    t = cyc;
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP = op;
    bus.REQ_ARG = 8'(arg);
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    k = 0;
    while (n_done == d0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    oor_en = 1'b0;
    chk("done_seen", 32'(n_done - d0), 1);
    chk("done_lat", 32'(done_cyc - t), 32'(e_lat));
    chk("done_err", 32'(done_err), 32'(e_err));
    chk("tap_pos", 32'(tap_pos), 32'(e_tap));
    chk("move_cnt", 32'(mv_cyc.size()), 32'(e_moves));
    chk("load_cnt", 32'(n_loads - l0), 32'(op == OP_LOAD));
    sticky = sticky | (e_err != 0);
    chk("err_range", 32'(err_range), 32'(sticky));
    foreach (mv_cyc[i]) begin
      chk("move_dir", 32'(mv_dir[i]), 32'(e_dir));
      chk("move_time", 32'(mv_cyc[i] - t), 32'(2 + i * (1 + S)));
    end
    mtap = e_tap;
  endtask
  task automatic clear_err();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    sticky = 1'b0;
    chk("err_clear", 32'(err_range), 0);
  endtask
  initial begin
    int m0, k, arg, oat;
    logic [1:0] op;
    bus.REQ_VALID = 1'b0;
    bus.REQ_OP = OP_INC;
    bus.REQ_ARG = '0;
    do_reset();
    run_req(OP_INC, 3, NONE);
    run_req(OP_SET, 0, NONE);
    run_req(OP_DEC, 1, NONE);
    clear_err();
    run_req(OP_INC, 5, 2);
    clear_err();
    run_req(OP_SET, 200, NONE);
    clear_err();
    run_req(OP_INC, 0, NONE);
    run_req(OP_SET, mtap, NONE);
    run_req(OP_SET, 125, NONE);
    run_req(OP_INC, 4, NONE);
    clear_err();
    run_req(OP_LOAD, 0, NONE);
    wait_ready();
    m0 = n_moves;
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP = OP_INC;
    bus.REQ_ARG = 8'd5;
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    k = 0;
    while (n_moves == m0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_move_seen", 32'(n_moves - m0), 1);
    @(negedge clk);
    m0 = n_done;
    do_reset();
    chk("no_done_after_rst", 32'(n_done - m0), 0);
    for (int r = 0; r < 30; r++) begin
      op = 2'($urandom_range(0, 3));
      if (op == OP_SET) begin
        if ($urandom_range(0, 9) == 0) arg = int'($urandom_range(128, 255));
        else arg = mtap + int'($urandom_range(0, 16)) - 8;
        if (arg < 0) arg = 0;
        if (arg > 255) arg = 255;
      end else arg = int'($urandom_range(0, 5));
      oat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : NONE;
      run_req(op, arg, oat);
      if (sticky && $urandom_range(0, 1) == 1) clear_err();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
